priority_grant_decoder: RTL

- Inverse end of the 4-input priority encoder: consumes a 3-bit encoded code {valid, idx[1:0]} and drives a registered one-hot 4-bit grant to the selected requester.
- Grant is held until the requester signals done, or until a hold-time limit expires.
- Break-before-make: one all-low gap cycle always separates successive grants.
- Sits between the encoder output and the shared-resource owners.

---
 rtl/priority_grant_decoder.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/priority_grant_decoder.sv
// Registered one-hot grant decoder for a 4-input priority encoder code, with hold limit and break-before-make gap.
// Optional one-deep pending slot for loads arriving while busy: define PRIORITY_GRANT_PENDING_EN.
module priority_grant_decoder #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] code,
    input  logic       code_load,
    input  logic       done,
    output logic [3:0] grant,
    output logic       busy,
    output logic [1:0] last_idx,
    output logic       timeout,
    output logic       overrun
);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(HOLD_MAX - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       grant_q, grant_d;
    logic [1:0]       last_idx_q, last_idx_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;
    logic             overrun_q, overrun_d;
    logic             valid_load;

`ifdef PRIORITY_GRANT_PENDING_EN
    logic             pend_valid_q, pend_valid_d;
    logic [1:0]       pend_idx_q, pend_idx_d;
`endif

    assign valid_load = code_load & code[2];

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        last_idx_d = last_idx_q;
        timeout_d  = 1'b0;
        overrun_d  = 1'b0;
`ifdef PRIORITY_GRANT_PENDING_EN
        pend_valid_d = pend_valid_q;
        pend_idx_d   = pend_idx_q;
`endif

        case (state_q)
            IDLE: begin
`ifdef PRIORITY_GRANT_PENDING_EN
                // A code captured during a pending-free GAP is served before new loads.
                if (pend_valid_q) begin
                    state_d      = GRANT;
                    grant_d      = 4'b0001 << pend_idx_q;
                    last_idx_d   = pend_idx_q;
                    cnt_d        = '0;
                    pend_valid_d = 1'b0;
                end else
`endif
                if (valid_load) begin
                    state_d    = GRANT;
                    grant_d    = 4'b0001 << code[1:0];
                    last_idx_d = code[1:0];
                    cnt_d      = '0;
                end
            end
            GRANT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (done) begin
                    state_d = GAP;
                    grant_d = '0;
                end else if (cnt_q == LIMIT) begin
                    state_d   = GAP;
                    grant_d   = '0;
                    timeout_d = 1'b1;
                end
            end
            GAP: begin
                state_d = IDLE;
                grant_d = '0;
`ifdef PRIORITY_GRANT_PENDING_EN
                if (pend_valid_q) begin
                    state_d      = GRANT;
                    grant_d      = 4'b0001 << pend_idx_q;
                    last_idx_d   = pend_idx_q;
                    cnt_d        = '0;
                    pend_valid_d = 1'b0;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        // Valid loads while busy: buffer the first one if possible, otherwise flag the drop.
        if ((state_q != IDLE) && valid_load) begin
`ifdef PRIORITY_GRANT_PENDING_EN
            if (!pend_valid_q) begin
                pend_valid_d = 1'b1;
                pend_idx_d   = code[1:0];
            end else begin
                overrun_d = 1'b1;
            end
`else
            overrun_d = 1'b1;
`endif
        end

        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            grant_q    <= '0;
            last_idx_q <= '0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef PRIORITY_GRANT_PENDING_EN
            pend_valid_q <= 1'b0;
            pend_idx_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            last_idx_q <= last_idx_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
            overrun_q  <= overrun_d;
`ifdef PRIORITY_GRANT_PENDING_EN
            pend_valid_q <= pend_valid_d;
            pend_idx_q   <= pend_idx_d;
`endif
        end
    end

    assign grant    = grant_q;
    assign busy     = busy_q;
    assign last_idx = last_idx_q;
    assign timeout  = timeout_q;
    assign overrun  = overrun_q;

endmodule
